alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_if.sv | 13 +
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ALU operand/result bundle. The master side drives opcode, operands and
// incoming flags; the slave side (the ALU) returns the registered result and flags.
interface alu_if;
  logic [3:0] oper;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] proc_flags_in;
  logic [7:0] out;
  logic [3:0] proc_flags_out;

  modport master (output oper, a_in, b_in, proc_flags_in, input out, proc_flags_out);
  modport slave  (input oper, a_in, b_in, proc_flags_in, output out, proc_flags_out);
endinterface

// File: rtl/alu.sv
// 8-bit ALU with a one-cycle registered result and Z/C/V/N flags.
// Optional macro ALU_ROTATE_EN enables rol/ror; otherwise those opcodes act as reserved.
module alu (
  input  logic   master_clk,
  input  logic   master_rst_n,
  alu_if.slave   bus
);
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
    OP_CMP = 4'd4,  OP_AND = 4'd5,  OP_ORR = 4'd6,  OP_XOR = 4'd7,
    OP_LSL = 4'd8,  OP_LSR = 4'd9,  OP_ASR = 4'd10, OP_ROL = 4'd11,
    OP_ROR = 4'd12, OP_NOT = 4'd13, OP_CPY = 4'd14, OP_RSV = 4'd15
  } op_e;

  op_e        op;
  logic [7:0] a, b, bx;
  logic       cin, cx, is_sub;
  logic [8:0] sum;
  logic       arith_v;
  logic [7:0] res, out_d;
  logic       c_o, v_o, rsv;
  logic [3:0] flags_d;

  assign op  = op_e'(bus.oper);
  assign a   = bus.a_in;
  assign b   = bus.b_in;
  assign cin = bus.proc_flags_in[1];

  // One shared adder: subtraction is a + ~b + carry, so C=1 means no borrow.
  assign is_sub  = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
  assign bx      = is_sub ? ~b : b;
  assign cx      = (op == OP_ADD) ? 1'b0 : ((op == OP_SUB) || (op == OP_CMP)) ? 1'b1 : cin;
  assign sum     = {1'b0, a} + {1'b0, bx} + {8'b0, cx};
  assign arith_v = (a[7] == bx[7]) && (sum[7] != a[7]);

  always_comb begin
    res   = 8'h00;
    c_o   = cin;
    v_o   = bus.proc_flags_in[2];
    rsv   = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        res = sum[7:0];
        c_o = sum[8];
        v_o = arith_v;
      end
      OP_AND: res = a & b;
      OP_ORR: res = a | b;
      OP_XOR: res = a ^ b;
      OP_LSL: begin res = {a[6:0], 1'b0}; c_o = a[7]; end
      OP_LSR: begin res = {1'b0, a[7:1]}; c_o = a[0]; end
      OP_ASR: begin res = {a[7], a[7:1]}; c_o = a[0]; end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin res = {a[6:0], cin}; c_o = a[7]; end
      OP_ROR: begin res = {cin, a[7:1]}; c_o = a[0]; end
`endif
      OP_NOT: res = ~a;
      OP_CPY: res = b;
      default: rsv = 1'b1;
    endcase
  end

  // cmp keeps a_in on the bus but its flags still describe the difference.
  assign out_d   = (op == OP_CMP) ? a : res;
  assign flags_d = rsv ? bus.proc_flags_in : {res[7], v_o, c_o, (res == 8'h00)};

  always_ff @(posedge master_clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      bus.out            <= 8'h00;
      bus.proc_flags_out <= 4'h0;
    end else begin
      bus.out            <= out_d;
      bus.proc_flags_out <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed expectations,
// a monitor compares one registered result per clock.
module tb_alu;
  logic master_clk = 1'b0;
  logic master_rst_n;

  alu_if bus ();

  alu dut (
    .master_clk   (master_clk),
    .master_rst_n (master_rst_n),
    .bus          (bus)
  );

  always #5 master_clk = ~master_clk;

  typedef struct {
    logic [7:0] o;
    logic [3:0] f;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [7:0] ao, input logic [3:0] af,
                       input logic [7:0] eo, input logic [3:0] ef);
    total++;
    if (ao !== eo || af !== ef) begin
      bad++;
      $display("FAIL %s: got out=%h flags=%b, expected out=%h flags=%b", nm, ao, af, eo, ef);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fi);
    bus.oper          = op;
    bus.a_in          = a;
    bus.b_in          = b;
    bus.proc_flags_in = fi;
  endtask

  // flags layout: {N, V, C, Z}
  task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] fi,
                       input logic [7:0] eo, input logic [3:0] ef);
    exp_t x;
    @(negedge master_clk);
    drive(op, a, b, fi);
    x.o = eo; x.f = ef; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge master_clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expectations left unchecked, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  always @(posedge master_clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      check(e.nm, bus.out, bus.proc_flags_out, e.o, e.f);
    end
  end

  initial begin
    master_rst_n = 1'b0;
    drive(4'd0, 8'h7F, 8'h01, 4'hF);
    #3 check("reset_async", bus.out, bus.proc_flags_out, 8'h00, 4'h0);
    repeat (2) @(posedge master_clk);
    #1 check("reset_hold", bus.out, bus.proc_flags_out, 8'h00, 4'h0);
    @(negedge master_clk);
    #2 master_rst_n = 1'b1;

    issue("add_wrap",   4'd0,  8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011);
    issue("add_ovf",    4'd0,  8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1100);
    issue("adc_cin",    4'd1,  8'h7F, 8'h01, 4'b0010, 8'h81, 4'b1100);
    issue("cmp_eq",     4'd4,  8'h05, 8'h05, 4'b0000, 8'h05, 4'b0011);
    issue("sub_borrow", 4'd2,  8'h00, 8'h01, 4'b0000, 8'hFF, 4'b1000);
    issue("sbc_c0",     4'd3,  8'h10, 8'h01, 4'b0000, 8'h0E, 4'b0010);
    issue("sbc_c1",     4'd3,  8'h10, 8'h01, 4'b0010, 8'h0F, 4'b0010);
    issue("sub_ovf",    4'd2,  8'h80, 8'h01, 4'b0000, 8'h7F, 4'b0110);
    issue("and_pass",   4'd5,  8'hF0, 8'h3C, 4'b0110, 8'h30, 4'b0110);
    issue("orr_zero",   4'd6,  8'h00, 8'h00, 4'b0100, 8'h00, 4'b0101);
    issue("xor",        4'd7,  8'hFF, 8'h0F, 4'b0000, 8'hF0, 4'b1000);
    issue("lsl",        4'd8,  8'h81, 8'h00, 4'b0100, 8'h02, 4'b0110);
    issue("lsr",        4'd9,  8'h81, 8'h00, 4'b0000, 8'h40, 4'b0010);
    issue("asr",        4'd10, 8'h81, 8'h00, 4'b0000, 8'hC0, 4'b1010);
    issue("not",        4'd13, 8'h00, 8'h00, 4'b0000, 8'hFF, 4'b1000);
    issue("cpy_zero",   4'd14, 8'h55, 8'h00, 4'b0110, 8'h00, 4'b0111);
    issue("reserved",   4'd15, 8'h12, 8'h34, 4'b1010, 8'h00, 4'b1010);
    issue("cmp_lt",     4'd4,  8'h03, 8'h05, 4'b0000, 8'h03, 4'b1000);
`ifdef ALU_ROTATE_EN
    issue("ror",        4'd12, 8'h01, 8'h00, 4'b0010, 8'h80, 4'b1010);
    issue("rol",        4'd11, 8'h80, 8'h00, 4'b0000, 8'h00, 4'b0011);
`else
    issue("ror_rsv",    4'd12, 8'h01, 8'h00, 4'b0010, 8'h00, 4'b0010);
    issue("rol_rsv",    4'd11, 8'h80, 8'h00, 4'b0100, 8'h00, 4'b0100);
`endif
    issue("add_after",  4'd0,  8'h01, 8'h01, 4'b1111, 8'h02, 4'b0000);
    drain("directed_drain");

    for (int i = 0; i < 256; i++) begin
      logic [7:0] av;
      av = 8'(i);
      issue("sweep_add", 4'd0, av, 8'h00, 4'b0000, av, {av[7], 1'b0, 1'b0, (i == 0)});
    end
    drain("sweep_drain");

    // Mid-cycle reset with a nonzero result held, then a different op pending.
    issue("pre_reset", 4'd0, 8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1100);
    drain("pre_reset_drain");
    @(negedge master_clk);
    drive(4'd7, 8'hA5, 8'h0F, 4'b0000);
    #2 master_rst_n = 1'b0;
    #1 check("rst_mid_immediate", bus.out, bus.proc_flags_out, 8'h00, 4'h0);
    @(posedge master_clk);
    #1 check("rst_mid_hold", bus.out, bus.proc_flags_out, 8'h00, 4'h0);
    @(negedge master_clk);
    #2 master_rst_n = 1'b1;
    #1 check("rst_release_hold", bus.out, bus.proc_flags_out, 8'h00, 4'h0);
    begin
      exp_t x;
      x.o = 8'hAA; x.f = 4'b1000; x.nm = "post_reset_first";
      q.push_back(x);
    end
    drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end
endmodule
